// File: rtl/regfile_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_queue
//  Description : Write-back buffer in front of the register file write port.
//                Writes arrive on a valid/ready interface, are held in an
//                in-order FIFO and drain one per cycle when the regfile port
//                is granted. A lookup port forwards the youngest pending value
//                for an address, so regfile read + lookup is always current.
//  Ports       : CLK, ASYNCRESET        clock / async active-high reset
//                in_valid/in_ready      producer write handshake
//                in_addr/in_data        write payload
//                rf_ready               regfile port granted this cycle
//                rf_write_en/addr/data  head entry presented to the regfile
//                lookup_addr            address being read from the regfile
//                lookup_hit/data        youngest pending match (0 on miss)
//                count                  entries currently held
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_queue #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESET,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_WIDTH-1:0]    in_addr,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     rf_ready,
  output logic                     rf_write_en,
  output logic [ADDR_WIDTH-1:0]    rf_write_addr,
  output logic [DATA_WIDTH-1:0]    rf_write_data,
  input  logic [ADDR_WIDTH-1:0]    lookup_addr,
  output logic                     lookup_hit,
  output logic [DATA_WIDTH-1:0]    lookup_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]    rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0]    count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;

  // Payload storage: intentionally not reset, validity is tracked separately.
  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  logic w_not_empty;
  logic w_push;
  logic w_pop;

  assign w_not_empty = (count_q != '0);
  assign w_pop       = w_not_empty & rf_ready;
  // A full queue still accepts when the head retires in the same cycle.
  assign in_ready    = (count_q < c_depth_cnt) | w_pop;
  assign w_push      = in_valid & in_ready;

  assign rf_write_en   = w_pop;
  assign rf_write_addr = w_not_empty ? addr_mem_q[rd_ptr_q] : '0;
  assign rf_write_data = w_not_empty ? data_mem_q[rd_ptr_q] : '0;
  assign count         = count_q;

  // Next-state for pointers, occupancy and per-entry valid bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    // Clear before set: on a full push+pop both pointers hit the same slot,
    // which must end up valid (it now holds the new write).
    if (w_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + c_ptr_one;
    end
    if (w_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + c_ptr_one;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      addr_mem_q[wr_ptr_q] <= in_addr;
      data_mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Forwarding: walk held entries oldest to youngest so the last match (the
  // youngest) wins. The entry being popped is still included because the
  // regfile is only updated at the coming edge.
  logic [c_ptr_w-1:0] w_scan_idx;

  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    w_scan_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_scan_idx = rd_ptr_q + c_ptr_w'(i);
      if (valid_q[w_scan_idx] && (addr_mem_q[w_scan_idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_mem_q[w_scan_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_queue
//  Description : Directed self-checking bench for regfile_write_queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_write_queue;

  logic       CLK;
  logic       ASYNCRESET;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_addr;
  logic [3:0] in_data;
  logic       rf_ready;
  logic       rf_write_en;
  logic [1:0] rf_write_addr;
  logic [3:0] rf_write_data;
  logic [1:0] lookup_addr;
  logic       lookup_hit;
  logic [3:0] lookup_data;
  logic [2:0] count;

  int n_cmp;
  int n_err;

  regfile_write_queue #(
    .ADDR_WIDTH(2),
    .DATA_WIDTH(4),
    .DEPTH     (4)
  ) u_dut (
    .CLK          (CLK),
    .ASYNCRESET   (ASYNCRESET),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .rf_ready     (rf_ready),
    .rf_write_en  (rf_write_en),
    .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .lookup_addr  (lookup_addr),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data),
    .count        (count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change right after a falling edge; outputs are sampled 1 time
  // unit later, well clear of the rising edge.
  task automatic next_cycle();
    @(negedge CLK);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // ---- 1: reset with garbage on inputs, then single push/drain ----
    ASYNCRESET  = 1'b1;
    in_valid    = 1'b1;
    in_addr     = 2'd3;
    in_data     = 4'hF;
    rf_ready    = 1'b1;
    lookup_addr = 2'd3;
    #3;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_wen", rf_write_en, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_hit", lookup_hit, 0);
    check_eq("rst_ldata", lookup_data, 0);
    check_eq("rst_waddr", rf_write_addr, 0);
    check_eq("rst_wdata", rf_write_data, 0);
    repeat (2) next_cycle();
    ASYNCRESET = 1'b0;
    in_valid   = 1'b1;
    in_addr    = 2'd2;
    in_data    = 4'd5;
    rf_ready   = 1'b1;
    #1;
    check_eq("t1_empty_wen", rf_write_en, 0);
    check_eq("t1_empty_cnt", count, 0);
    next_cycle();
    in_valid = 1'b0;
    #1;
    check_eq("t1_wen", rf_write_en, 1);
    check_eq("t1_waddr", rf_write_addr, 2);
    check_eq("t1_wdata", rf_write_data, 5);
    check_eq("t1_cnt1", count, 1);
    next_cycle();
    #1;
    check_eq("t1_cnt0", count, 0);
    check_eq("t1_wen0", rf_write_en, 0);

    // ---- 2: fill, stall, simultaneous push/pop when full, drain ----
    next_cycle();
    rf_ready    = 1'b0;
    lookup_addr = 2'd1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_addr  = 2'd1;
      in_data  = 4'(3 + k);
      #1;
      check_eq("t2_fill_ready", in_ready, 1);
      next_cycle();
    end
    in_data = 4'd7;
    #1;
    check_eq("t2_full_cnt", count, 4);
    check_eq("t2_full_ready", in_ready, 0);
    check_eq("t2_full_wen", rf_write_en, 0);
    check_eq("t2_head", rf_write_data, 3);
    check_eq("t2_lk_data", lookup_data, 6);
    next_cycle();
    #1;
    check_eq("t2_stall_cnt", count, 4);
    check_eq("t2_stall_head", rf_write_data, 3);
    rf_ready = 1'b1;
    #1;
    check_eq("t2_pp_wen", rf_write_en, 1);
    check_eq("t2_pp_ready", in_ready, 1);
    next_cycle();
    in_valid = 1'b0;
    #1;
    check_eq("t2_pp_cnt", count, 4);
    check_eq("t2_lk_young", lookup_data, 7);
    for (int j = 0; j < 4; j++) begin
      check_eq("t2_drain_data", rf_write_data, 32'(4 + j));
      check_eq("t2_drain_cnt", count, 32'(4 - j));
      next_cycle();
      #1;
    end
    check_eq("t2_end_cnt", count, 0);
    check_eq("t2_end_wen", rf_write_en, 0);

    // ---- 3: forwarding with duplicate addresses ----
    rf_ready    = 1'b0;
    lookup_addr = 2'd3;
    in_valid    = 1'b1;
    in_addr     = 2'd3;
    in_data     = 4'd9;
    next_cycle();
    in_data = 4'd12;
    next_cycle();
    in_valid = 1'b0;
    #1;
    check_eq("t3_cnt", count, 2);
    check_eq("t3_hit", lookup_hit, 1);
    check_eq("t3_data", lookup_data, 12);
    lookup_addr = 2'd0;
    #1;
    check_eq("t3_miss_hit", lookup_hit, 0);
    check_eq("t3_miss_data", lookup_data, 0);
    lookup_addr = 2'd3;
    rf_ready    = 1'b1;
    #1;
    check_eq("t3_pop_hit", lookup_hit, 1);
    check_eq("t3_pop_data", lookup_data, 12);
    next_cycle();
    #1;
    check_eq("t3_last_data", lookup_data, 12);
    check_eq("t3_last_wdata", rf_write_data, 12);
    next_cycle();
    #1;
    check_eq("t3_drained_hit", lookup_hit, 0);
    check_eq("t3_drained_cnt", count, 0);

    // ---- 4: same-cycle push is not forwarded ----
    in_valid    = 1'b1;
    in_addr     = 2'd0;
    in_data     = 4'd8;
    lookup_addr = 2'd0;
    rf_ready    = 1'b1;
    #1;
    check_eq("t4_same_hit", lookup_hit, 0);
    next_cycle();
    in_valid = 1'b0;
    #1;
    check_eq("t4_hit", lookup_hit, 1);
    check_eq("t4_data", lookup_data, 8);
    check_eq("t4_wen", rf_write_en, 1);
    next_cycle();
    #1;
    check_eq("t4_after_hit", lookup_hit, 0);

    // ---- 5: pointer wrap with back-to-back push/pop ----
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_addr  = 2'(i % 4);
      in_data  = 4'(i + 1);
      #1;
      if (i == 0) begin
        check_eq("t5_first_wen", rf_write_en, 0);
        check_eq("t5_first_cnt", count, 0);
      end else begin
        check_eq("t5_wen", rf_write_en, 1);
        check_eq("t5_waddr", rf_write_addr, 32'((i - 1) % 4));
        check_eq("t5_wdata", rf_write_data, 32'(i));
        check_eq("t5_cnt", count, 1);
        check_eq("t5_ready", in_ready, 1);
      end
      next_cycle();
    end
    in_valid = 1'b0;
    #1;
    check_eq("t5_tail_waddr", rf_write_addr, 1);
    check_eq("t5_tail_wdata", rf_write_data, 10);
    next_cycle();
    #1;
    check_eq("t5_end_cnt", count, 0);

    // ---- 6: asynchronous reset mid-drain ----
    rf_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_addr  = 2'(k);
      in_data  = 4'(k);
      next_cycle();
    end
    in_valid    = 1'b0;
    rf_ready    = 1'b1;
    lookup_addr = 2'd2;
    #1;
    check_eq("t6_pre_cnt", count, 3);
    #1;
    ASYNCRESET = 1'b1;
    #1;
    check_eq("t6_rst_cnt", count, 0);
    check_eq("t6_rst_ready", in_ready, 1);
    check_eq("t6_rst_wen", rf_write_en, 0);
    check_eq("t6_rst_hit", lookup_hit, 0);
    check_eq("t6_rst_ldata", lookup_data, 0);
    check_eq("t6_rst_waddr", rf_write_addr, 0);
    check_eq("t6_rst_wdata", rf_write_data, 0);
    next_cycle();
    ASYNCRESET  = 1'b0;
    lookup_addr = 2'd1;
    #1;
    check_eq("t6_post_hit", lookup_hit, 0);
    check_eq("t6_post_wen", rf_write_en, 0);
    next_cycle();
    #1;
    check_eq("t6_post_cnt", count, 0);
    check_eq("t6_post_wen2", rf_write_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
